idx_seq: RTL
============

Name: idx_seq

Overview:
Parametrised, sequential successor to the combinational x-index incrementer. It generates one index sweep from 0 up to a programmable last index, with a start/done handshake and a consumer stall input (en_i). It sits between the convolution control FSM and the memory address logic, and serves as either the x or the y loop counter. Index width is set by parameter; an optional mode adds a programmable stride.

Parameters:
WIDTH, 6, bit width of the index and the limit (the sweep covers up to 2^WIDTH indices)

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst  input  1  reset, synchronous, active-high
start_i  input  1  begin a sweep; sampled only in IDLE
limit_i  input  WIDTH  last index of the sweep, inclusive; latched when start_i is accepted
en_i  input  1  consumer accepts the current index this cycle; when low, the sequencer stalls
idx_o  output  WIDTH  current index
valid_o  output  1  idx_o holds a valid index
last_o  output  1  the current index is the final one of the sweep
busy_o  output  1  a sweep is in progress (RUN state)
done_o  output  1  one-cycle pulse after the final index is accepted

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values: state=IDLE, idx_o=0, valid_o=0, last_o=0, busy_o=0, done_o=0, latched limit=0.
- The state machine has three states: IDLE, RUN, DONE.
- IDLE:
  - If start_i=1, latch limit_i, set idx_o=0, and go to RUN.
  - valid_o and busy_o are 1 starting the next cycle, so the first index appears 1 cycle after start.
  - If start_i=0, stay in IDLE.
- RUN:
  - valid_o=1 and busy_o=1.
  - If en_i=1 and last_o=0, then idx_o <= idx_o + 1.
  - If en_i=1 and last_o=1, go to DONE. valid_o and busy_o go to 0 and idx_o holds its value.
  - If en_i=0, hold all registers (stall); there is no limit on stall length.
- DONE:
  - done_o=1 for exactly this one cycle, then the next state is IDLE.
  - A start_i asserted during DONE is ignored.
  - A new sweep can be accepted on the cycle after DONE (start-to-start minimum is limit+3 cycles with en_i held high).
- last_o is combinational: valid_o && (idx_o == latched limit).
  - With the stride feature, it is valid_o && (idx_o + step >= limit+1), evaluated in WIDTH+1 bits.
- Arithmetic:
  - Increments are computed in WIDTH+1 bits.
  - idx_o never wraps past the limit or past 2^WIDTH-1.
  - limit_i = 2^WIDTH-1 yields a full sweep 0..2^WIDTH-1 with no overflow.
- limit_i = 0: the sweep is a single index 0; last_o=1 on the first valid cycle.
- Changes to start_i or limit_i while in RUN or DONE are ignored; the latched limit is stable for the whole sweep.
- rst asserted in any state returns all outputs to their reset values on the next edge. No done_o pulse is issued for an aborted sweep.
- rst and start_i asserted in the same cycle: rst wins.
- Outputs idx_o, valid_o, busy_o and done_o are registered; last_o is combinational from registers only.

Optional Feature:
Macro: IDX_SEQ_STRIDE_EN
- Defined:
  - Adds input port step_i (WIDTH bits), latched with limit_i on start.
  - The index advances by the latched step. A step of 0 is treated as 1.
  - The sweep ends at the largest index k*step that is <= limit; idx_o never exceeds the limit.
- Not defined:
  - The step_i port is absent and the step is fixed at 1.
  - Behaviour is otherwise identical.

Test Plan:
- Reset check: rst=1 for 2 cycles -> idx_o=0, valid_o=0, busy_o=0, done_o=0, last_o=0.
- Basic sweep: limit_i=5, start_i pulse, en_i=1 -> idx_o sequence 0,1,2,3,4,5 on consecutive cycles starting 1 cycle after start; last_o=1 only at 5; done_o pulses 1 cycle after idx 5 is accepted; busy_o=0 afterwards.
- Stall: limit_i=3, en_i=0 for 4 cycles while idx_o=1 -> idx_o stays at 1 and valid_o stays 1; the sweep then resumes to 3 and done_o is a single pulse.
- Boundaries:
  - limit_i=0 -> exactly one valid cycle, with idx_o=0 and last_o=1.
  - limit_i=63 (WIDTH=6) -> 64 indices 0..63, no wrap to 0.
- Abort and ignored start:
  - rst=1 at idx_o=2 of a limit=10 sweep -> outputs reset next cycle and no done_o.
  - start_i=1 held throughout RUN -> no restart mid-sweep.
- IDX_SEQ_STRIDE_EN defined:
  - step_i=3, limit_i=10 -> idx_o 0,3,6,9; last_o at 9.
  - step_i=0 -> behaves as step 1.

Source files
------------

// File: rtl/idx_seq.sv
// Index sequencer: sweeps idx_o from 0 to a latched limit with start/done handshake and en_i stall.
// Optional macro IDX_SEQ_STRIDE_EN adds step_i (programmable stride, 0 treated as 1).
module idx_seq #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] limit_i,
`ifdef IDX_SEQ_STRIDE_EN
    input  logic [WIDTH-1:0] step_i,
`endif
    input  logic             en_i,
    output logic [WIDTH-1:0] idx_o,
    output logic             valid_o,
    output logic             last_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic [WIDTH-1:0] step_q;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   idx_sum;
    logic [WIDTH:0]   lim_p1;
    logic             last_w;

    function automatic logic [WIDTH-1:0] eff_step(input logic [WIDTH-1:0] s);
        return (s == '0) ? WIDTH'(1) : s;
    endfunction

`ifdef IDX_SEQ_STRIDE_EN
    logic [WIDTH-1:0] step_d;

    always_ff @(posedge clk) begin
        if (rst)
            step_q <= WIDTH'(1);
        else
            step_q <= step_d;
    end

    always_comb begin
        step_d = step_q;
        if (state_q == IDLE && start_i)
            step_d = eff_step(step_i);
    end
`else
    assign step_q = eff_step('0);
`endif

    // Wide compare: the next stride overshooting the limit marks the final index, never wraps.
    assign idx_sum = {1'b0, idx_q} + {1'b0, step_q};
    assign lim_p1  = {1'b0, lim_q} + (WIDTH+1)'(1);
    assign last_w  = valid_q && (idx_sum >= lim_p1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            lim_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lim_q   <= lim_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lim_d   = lim_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    lim_d   = limit_i;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (en_i) begin
                    if (last_w) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_sum[WIDTH-1:0];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign idx_o   = idx_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign last_o  = last_w;

endmodule
